// File: rtl/rx_pkg.sv
// Shared constants, FSM state type and symbol placement helper for the
// rx symbol packer and its FIFO.
package rx_pkg;

  localparam int SYM_W         = 2;
  localparam int WORD_W        = 32;
  localparam int SYMS_PER_WORD = WORD_W / SYM_W;
  localparam int IDX_W         = $clog2(SYMS_PER_WORD);
  localparam int ENTRY_W       = WORD_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    DROP
  } state_e;

  // Symbol idx of a word occupies bits [WORD_W-1-SYM_W*idx -: SYM_W] (MSB first).
  function automatic logic [WORD_W-1:0] place_sym(input logic [WORD_W-1:0] word,
                                                  input logic [IDX_W-1:0]  idx,
                                                  input logic [SYM_W-1:0]  sym);
    logic [WORD_W-1:0] w;
    w = word;
    w[WORD_W-1-SYM_W*int'(idx) -: SYM_W] = sym;
    return w;
  endfunction

endpackage

// File: rtl/rx_sym_packer_if.sv
// Packed-word valid/ready stream from the symbol packer to the data mover.
interface rx_sym_packer_if #(
  parameter int WORD_W = rx_pkg::WORD_W
);
  logic [WORD_W-1:0] word;
  logic              word_last;
  logic              word_vld;
  logic              word_rdy;

  modport master (output word, output word_last, output word_vld, input  word_rdy);
  modport slave  (input  word, input  word_last, input  word_vld, output word_rdy);
endinterface

// File: rtl/rx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A written entry becomes visible
// at the head one cycle after the write edge; count and full track real occupancy.
module rx_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_wr_vis;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign o_count    = w_count;
  assign o_full     = (w_count == (AW+1)'(DEPTH));
  assign o_empty    = (r_rd_ptr == r_wr_vis);
  assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // NOTE: storage is deliberately not reset; pointers alone define validity,
  // and leaving the array reset-free lets it map onto RAM.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_wr_vis <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_vis <= r_wr_ptr;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rx_sym_packer.sv
// Packs framed QPSK hard decisions MSB-first into 32-bit words, buffers them
// in a FWFT FIFO and reports frame length, completion, errors and overflow.
module rx_sym_packer
  import rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [SYM_W-1:0]              i_sym,
  input  logic                          i_sym_vld,
  input  logic                          i_sof,
  input  logic                          i_eof,
  rx_sym_packer_if.master               o_word_if,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic [LEN_W-1:0]              o_frame_len,
  output logic                          o_frame_done,
  output logic                          o_frame_err,
  output logic                          o_overflow
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SYMS_PER_WORD - 1);

  state_e              r_state, w_state_nxt;
  logic [WORD_W-1:0]   r_shift, w_shift_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [LEN_W-1:0]    r_len, w_len_nxt;
  logic                r_err, w_err_nxt;
  logic [LEN_W-1:0]    r_frame_len;
  logic                r_done, r_done_err, r_overflow;

  logic                w_push, w_push_last;
  logic [WORD_W-1:0]   w_push_word;
  logic                w_done, w_done_err;
  logic [LEN_W-1:0]    w_len_done;
  logic [WORD_W-1:0]   w_placed, w_first;
  logic [LEN_W-1:0]    w_len_inc;
  logic                w_fifo_full, w_fifo_empty, w_pop, w_fifo_blocked;
  logic [ENTRY_W-1:0]  w_head;

  assign w_placed  = place_sym(r_shift, r_idx, i_sym);
  assign w_first   = place_sym('0, '0, i_sym);
  assign w_len_inc = (r_len == '1) ? r_len : r_len + 1'b1;

  // A push is lost only when the FIFO is full and nothing leaves this cycle.
  assign w_pop          = o_word_if.word_vld && o_word_if.word_rdy;
  assign w_fifo_blocked = w_fifo_full && !w_pop;

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_err_nxt   = r_err;
    w_push      = 1'b0;
    w_push_word = w_placed;
    w_push_last = 1'b0;
    w_done      = 1'b0;
    w_done_err  = 1'b0;
    w_len_done  = w_len_inc;

    if (i_sym_vld) begin
      if (i_sof) begin
        // Restart aborts any frame in flight and reports it as corrupted.
        if (r_state != IDLE) begin
          w_done     = 1'b1;
          w_done_err = 1'b1;
          w_len_done = r_len;
        end
        w_len_nxt   = LEN_W'(1);
        w_err_nxt   = 1'b0;
        w_shift_nxt = w_first;
        w_idx_nxt   = IDX_W'(1);
        w_state_nxt = PACK;
        if (i_eof) begin
          w_push      = 1'b1;
          w_push_word = w_first;
          w_push_last = 1'b1;
          w_shift_nxt = '0;
          w_idx_nxt   = '0;
          w_state_nxt = IDLE;
          if (r_state == IDLE) begin
            w_done     = 1'b1;
            w_done_err = w_fifo_blocked;
            w_len_done = LEN_W'(1);
          end
        end
      end else begin
        unique case (r_state)
          PACK: begin
            w_len_nxt = w_len_inc;
            if (i_eof) begin
              w_push      = 1'b1;
              w_push_last = 1'b1;
              w_done      = 1'b1;
              w_done_err  = r_err || w_fifo_blocked;
              w_shift_nxt = '0;
              w_idx_nxt   = '0;
              w_state_nxt = IDLE;
            end else if (r_idx == IDX_LAST) begin
              w_push      = 1'b1;
              w_shift_nxt = '0;
              w_idx_nxt   = '0;
              if (w_fifo_blocked) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = DROP;
              end
            end else begin
              w_shift_nxt = w_placed;
              w_idx_nxt   = r_idx + 1'b1;
            end
          end
          DROP: begin
            w_len_nxt = w_len_inc;
            if (i_eof) begin
              w_done      = 1'b1;
              w_done_err  = 1'b1;
              w_state_nxt = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_err       <= 1'b0;
      r_frame_len <= '0;
      r_done      <= 1'b0;
      r_done_err  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_idx      <= w_idx_nxt;
      r_len      <= w_len_nxt;
      r_err      <= w_err_nxt;
      r_done     <= w_done;
      r_done_err <= w_done_err;
      if (w_done)                   r_frame_len <= w_len_done;
      if (w_push && w_fifo_blocked) r_overflow  <= 1'b1;
    end
  end

  rx_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_data ({w_push_last, w_push_word}),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (o_fifo_cnt)
  );

  assign o_word_if.word      = w_head[WORD_W-1:0];
  assign o_word_if.word_last = w_head[WORD_W];
  assign o_word_if.word_vld  = !w_fifo_empty;

  assign o_frame_len  = r_frame_len;
  assign o_frame_done = r_done;
  assign o_frame_err  = r_done_err;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_rx_sym_packer.sv
// Self-checking bench: frame table plus corner sequences, with a word
// scoreboard fed by the stimulus and drained by a negedge output monitor.
module tb_rx_sym_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sym = '0;
  logic        sym_vld = 1'b0, sof = 1'b0, eof = 1'b0;
  logic [6:0]  fifo_cnt;
  logic [15:0] frame_len;
  logic        frame_done, frame_err, overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [32:0] exp_q[$];
  logic [31:0] rx_log[$];
  logic [16:0] done_q[$];

  typedef struct {
    string       name;
    int          nsym;
    logic [63:0] pat;
    int          nwords;
    logic [31:0] first;
    int          len;
  } vec_t;
  vec_t vecs[4];

  rx_sym_packer_if #(.WORD_W(32)) word_if ();

  rx_sym_packer #(.FIFO_DEPTH(64), .LEN_W(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sym        (sym),
    .i_sym_vld    (sym_vld),
    .i_sof        (sof),
    .i_eof        (eof),
    .o_word_if    (word_if),
    .o_fifo_cnt   (fifo_cnt),
    .o_frame_len  (frame_len),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (word_if.word_vld && word_if.word_rdy) begin
        rx_log.push_back(word_if.word);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_word: got %h expected none", word_if.word);
        end else begin
          check("word", {word_if.word_last, word_if.word}, exp_q.pop_front());
        end
      end
      if (frame_done) done_q.push_back({frame_err, frame_len});
      else if (frame_err) begin
        n_cmp++;
        n_fail++;
        $display("FAIL err_without_done: got err=1 expected 0");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic f_sof, input logic f_eof);
    sym = s; sym_vld = 1'b1; sof = f_sof; eof = f_eof;
    tick();
    sym_vld = 1'b0; sof = 1'b0; eof = 1'b0;
  endtask

  function automatic logic [1:0] sym_at(input logic [63:0] p, input int k);
    return p[63-2*(k%32) -: 2];
  endfunction

  // Drives one frame; expected words are queued as each word completes.
  task automatic send_frame(input logic [63:0] pat, input int nsym, input bit with_eof, input int cap);
    logic [31:0] cur;
    logic [1:0]  s;
    bit          last;
    int          queued;
    cur = '0;
    queued = 0;
    for (int k = 0; k < nsym; k++) begin
      s = sym_at(pat, k);
      cur[31-2*(k%16) -: 2] = s;
      last = with_eof && (k == nsym - 1);
      if ((k % 16 == 15) || last) begin
        if (queued < cap) exp_q.push_back({last, cur});
        queued++;
        cur = '0;
      end
      send(s, k == 0, last);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick();
    check({name, "_drained"}, exp_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic pop_pulse(input string name, input logic exp_err, input int exp_len, input bit chk_len);
    logic [16:0] p;
    if (done_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_pulse: got none expected done", name);
    end else begin
      p = done_q.pop_front();
      check({name, "_err"}, p[16], exp_err);
      if (chk_len) check({name, "_len"}, p[15:0], exp_len);
    end
  endtask

  initial begin
    int n0;
    vecs[0] = '{"full_word", 16, 64'h1B1B_1B1B_1B1B_1B1B, 1, 32'h1B1B_1B1B, 16};
    vecs[1] = '{"partial",    5, 64'hFF40_0000_0000_0000, 1, 32'hFF40_0000,  5};
    vecs[2] = '{"single",     1, 64'h8000_0000_0000_0000, 1, 32'h8000_0000,  1};
    vecs[3] = '{"forty",     40, 64'hE4E4_E4E4_0F0F_0F0F, 3, 32'hE4E4_E4E4, 40};

    word_if.word_rdy = 1'b1;
    repeat (3) tick();
    check("rst_vld",      word_if.word_vld, 0);
    check("rst_cnt",      fifo_cnt, 0);
    check("rst_done",     frame_done, 0);
    check("rst_err",      frame_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_len",      frame_len, 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      n0 = rx_log.size();
      send_frame(vecs[i].pat, vecs[i].nsym, 1'b1, 999);
      wait_drain(vecs[i].name);
      check({vecs[i].name, "_npulse"}, done_q.size(), 1);
      pop_pulse(vecs[i].name, 1'b0, vecs[i].len, 1'b1);
      check({vecs[i].name, "_nwords"}, rx_log.size() - n0, vecs[i].nwords);
      if (rx_log.size() > n0) check({vecs[i].name, "_first"}, rx_log[n0], vecs[i].first);
    end

    // Word pushed on the eof edge is visible only after the following edge.
    word_if.word_rdy = 1'b0;
    send_frame(64'h8000_0000_0000_0000, 1, 1'b1, 999);
    check("lat_vld_early", word_if.word_vld, 0);
    check("lat_cnt",       fifo_cnt, 1);
    tick();
    check("lat_vld",       word_if.word_vld, 1);
    check("lat_head",      {word_if.word_last, word_if.word}, {1'b1, 32'h8000_0000});
    word_if.word_rdy = 1'b1;
    wait_drain("lat");
    pop_pulse("lat", 1'b0, 1, 1'b1);

    // Symbols with no sof are ignored, eof included.
    n0 = rx_log.size();
    repeat (4) send(2'd3, 1'b0, 1'b0);
    send(2'd1, 1'b0, 1'b1);
    repeat (3) tick();
    check("pre_npulse", done_q.size(), 0);
    check("pre_cnt",    fifo_cnt, 0);
    check("pre_words",  rx_log.size() - n0, 0);

    // Restart: sof at symbol 20 aborts the frame after one full word.
    n0 = rx_log.size();
    send_frame(64'h1B1B_1B1B_1B1B_1B1B, 20, 1'b0, 999);
    send_frame(64'h6D00_0000_0000_0000, 5, 1'b1, 999);
    wait_drain("restart");
    check("restart_npulse", done_q.size(), 2);
    pop_pulse("abort", 1'b1, 0, 1'b0);
    pop_pulse("restart", 1'b0, 5, 1'b1);
    check("restart_nwords", rx_log.size() - n0, 2);
    if (rx_log.size() > n0 + 1) check("restart_word", rx_log[n0+1], 32'h6D00_0000);

    // Backpressure: 65 words into a 64-deep FIFO loses the final word.
    word_if.word_rdy = 1'b0;
    send_frame(64'hE4E4_E4E4_1B1B_1B1B, 1040, 1'b1, 64);
    repeat (2) tick();
    check("ovf_cnt",      fifo_cnt, 64);
    check("ovf_flag",     overflow, 1);
    check("ovf_npulse",   done_q.size(), 1);
    pop_pulse("ovf", 1'b1, 1040, 1'b1);
    n0 = rx_log.size();
    word_if.word_rdy = 1'b1;
    wait_drain("ovf");
    check("ovf_nwords",   rx_log.size() - n0, 64);
    check("ovf_cnt_end",  fifo_cnt, 0);
    check("ovf_sticky",   overflow, 1);

    // Reset mid-frame discards silently; the next frame packs correctly.
    n0 = rx_log.size();
    send_frame(64'h1B1B_1B1B_1B1B_1B1B, 7, 1'b0, 999);
    rst = 1'b1;
    tick();
    check("mrst_vld",      word_if.word_vld, 0);
    check("mrst_cnt",      fifo_cnt, 0);
    check("mrst_overflow", overflow, 0);
    check("mrst_len",      frame_len, 0);
    check("mrst_done",     frame_done, 0);
    tick();
    rst = 1'b0;
    tick();
    check("mrst_npulse", done_q.size(), 0);
    send_frame(vecs[0].pat, vecs[0].nsym, 1'b1, 999);
    wait_drain("post_rst");
    pop_pulse("post_rst", 1'b0, 16, 1'b1);
    check("post_rst_nwords", rx_log.size() - n0, 1);
    if (rx_log.size() > n0) check("post_rst_word", rx_log[n0], 32'h1B1B_1B1B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
